// File: rtl/alu_cu_pkg.sv
// Shared opcode constants, instruction field positions and FSM state type
// for the ALU control unit.
package alu_cu_pkg;

   localparam logic [5:0] OP_NOP    = 6'b000000;
   localparam logic [5:0] OP_LI     = 6'b000001;
   localparam logic [5:0] OP_ADD    = 6'b010000;
   localparam logic [5:0] OP_SUB    = 6'b010001;
   localparam logic [5:0] OP_EQ     = 6'b100000;

   // Top two opcode bits select the class; 00 is reserved for internal ops
   localparam logic [5:0] CLS_MASK  = 6'b110000;
   localparam logic [5:0] CLS_ARITH = 6'b010000;

   localparam int OPC_LSB = 26;
   localparam int RD_LSB  = 23;
   localparam int RS1_LSB = 20;
   localparam int RS2_LSB = 17;
   localparam int UC_BIT  = 16;
   localparam int IMM_LSB = 0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   function automatic logic is_alu_op(input logic [5:0] op);
      return (op & CLS_MASK) != 6'b000000;
   endfunction

   function automatic logic is_arith_op(input logic [5:0] op);
      return (op & CLS_MASK) == CLS_ARITH;
   endfunction

endpackage

// File: rtl/alu_cu_regfile.sv
// Register file: two combinational read ports, one synchronous write port,
// entry 0 hardwired to zero.
module alu_cu_regfile #(
   parameter int DATA_W = 32,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [2:0]        raddr1,
   input  logic [2:0]        raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2,
   input  logic              we,
   input  logic [2:0]        waddr,
   input  logic [DATA_W-1:0] wdata
);

   logic [NREGS-1:1][DATA_W-1:0] regs;

   function automatic logic [DATA_W-1:0] rd_port(input logic [2:0] addr);
      if (addr == 3'd0 || 32'(addr) >= NREGS)
         return '0;
      return regs[addr];
   endfunction

   assign rdata1 = rd_port(raddr1);
   assign rdata2 = rd_port(raddr2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs <= '0;
      end else if (we && waddr != 3'd0 && 32'(waddr) < NREGS) begin
         regs[waddr] <= wdata;
      end
   end

endmodule

// File: rtl/alu_ctrl_unit.sv
// Sequences one host instruction at a time through an external combinational ALU.
// Optional carry chain into alu_cin / flag c: define ALU_CU_CARRY_CHAIN_EN.
module alu_ctrl_unit
   import alu_cu_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int NREGS  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_result,
   output logic [2:0]        out_flags,
   output logic              out_err,
   output logic [5:0]        alu_opcode,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic              alu_cin,
   input  logic [DATA_W-1:0] alu_ans,
   input  logic              alu_ans_opt,
   input  logic              alu_z,
   input  logic              alu_n
);

   state_t            state, state_nxt;
   logic [5:0]        op_in, op_q;
   logic [2:0]        rs1_in, rs2_in, rd_q;
   logic [15:0]       imm_q;
   logic [DATA_W-1:0] rs1_data, rs2_data, res_val;
   logic              accept, in_exec;
   logic              wr_en, err_val, z_val, n_val;
   logic              z_q, n_q, c_bit;

   assign op_in   = in_instr[OPC_LSB +: 6];
   assign rs1_in  = in_instr[RS1_LSB +: 3];
   assign rs2_in  = in_instr[RS2_LSB +: 3];
   assign accept  = in_valid & in_ready;
   assign in_exec = (state == S_EXEC);

   alu_cu_regfile #(
      .DATA_W(DATA_W),
      .NREGS (NREGS)
   ) u_regfile (
      .clk   (clk),
      .rst   (rst),
      .raddr1(rs1_in),
      .raddr2(rs2_in),
      .rdata1(rs1_data),
      .rdata2(rs2_data),
      .we    (in_exec & wr_en),
      .waddr (rd_q),
      .wdata (res_val)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (in_valid)  state_nxt = S_EXEC;
         S_EXEC:                 state_nxt = S_RESP;
         S_RESP:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == S_IDLE) & ~rst;
      out_valid = (state == S_RESP);
   end

   // Operands are sampled at accept, so rs==rd always sees the pre-write value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q       <= '0;
         rd_q       <= '0;
         imm_q      <= '0;
         alu_opcode <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
      end else if (accept) begin
         op_q  <= op_in;
         rd_q  <= in_instr[RD_LSB +: 3];
         imm_q <= in_instr[IMM_LSB +: 16];
         if (is_alu_op(op_in)) begin
            alu_opcode <= op_in;
            alu_a      <= rs1_data;
            alu_b      <= rs2_data;
         end
      end
   end

   always_comb begin
      res_val = '0;
      wr_en   = 1'b0;
      err_val = 1'b0;
      z_val   = z_q;
      n_val   = n_q;
      if (is_alu_op(op_q)) begin
         res_val = alu_ans;
         wr_en   = 1'b1;
         z_val   = alu_z;
         n_val   = alu_n;
      end else if (op_q == OP_LI) begin
         res_val = DATA_W'(imm_q);
         wr_en   = 1'b1;
         z_val   = (imm_q == 16'd0);
         n_val   = res_val[DATA_W-1];
      end else if (op_q != OP_NOP) begin
         err_val = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_result <= '0;
         out_err    <= 1'b0;
         z_q        <= 1'b0;
         n_q        <= 1'b0;
      end else if (in_exec) begin
         out_result <= res_val;
         out_err    <= err_val;
         z_q        <= z_val;
         n_q        <= n_val;
      end
   end

`ifdef ALU_CU_CARRY_CHAIN_EN
   logic c_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q     <= 1'b0;
         alu_cin <= 1'b0;
      end else begin
         if (accept && is_alu_op(op_in))
            alu_cin <= in_instr[UC_BIT] & c_q;
         if (in_exec && is_arith_op(op_q))
            c_q <= alu_ans_opt;
      end
   end

   assign c_bit = c_q;
`else
   logic unused_carry;

   assign alu_cin      = 1'b0;
   assign c_bit        = 1'b0;
   assign unused_carry = ^{alu_ans_opt, in_instr[UC_BIT]};
`endif

   assign out_flags = {c_bit, z_q, n_q};

endmodule

// File: tb/tb_alu_ctrl_unit.sv
// Directed bench for alu_ctrl_unit with a behavioural 32-bit ALU on the far side.
module tb_alu_ctrl_unit;
   import alu_cu_pkg::*;

`ifdef ALU_CU_CARRY_CHAIN_EN
   localparam bit CC = 1'b1;
`else
   localparam bit CC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [31:0] in_instr, out_result, alu_a, alu_b, alu_ans;
   logic [2:0]  out_flags;
   logic [5:0]  alu_opcode;
   logic        alu_cin, alu_ans_opt, alu_z, alu_n;
   logic [31:0] ans_m;
   logic        opt_m;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_ctrl_unit #(.DATA_W(32), .NREGS(8)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags), .out_err(out_err),
      .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
      .alu_ans(alu_ans), .alu_ans_opt(alu_ans_opt), .alu_z(alu_z), .alu_n(alu_n)
   );

   always_comb begin
      ans_m = '0;
      opt_m = 1'b0;
      case (alu_opcode)
         OP_ADD:  {opt_m, ans_m} = {1'b0, alu_a} + {1'b0, alu_b} + {32'b0, alu_cin};
         OP_SUB:  {opt_m, ans_m} = {1'b0, alu_a} - {1'b0, alu_b} - {32'b0, alu_cin};
         OP_EQ:   ans_m = (alu_a == alu_b) ? 32'd1 : 32'd0;
         default: ;
      endcase
   end

   assign alu_ans     = ans_m;
   assign alu_ans_opt = opt_m;
   assign alu_z       = (ans_m == 32'd0);
   assign alu_n       = ans_m[31];

   function automatic logic [31:0] enc(input logic [5:0] op, input int rd, input int rs1,
                                       input int rs2, input logic uc, input logic [15:0] imm);
      return {op, 3'(rd), 3'(rs1), 3'(rs2), uc, imm};
   endfunction

   // Called at posedge+1; returns at posedge+1 of the first RESP cycle.
   // cyc counts cycles from the accept cycle (accept cycle = 0).
   task automatic issue(input logic [31:0] instr, output logic [31:0] res,
                        output logic [2:0] fl, output logic er, output int cyc);
      int t;
      t = 0;
      while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
      in_valid = 1'b1;
      in_instr = instr;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (!out_valid || t >= 20) begin
         errors++;
         $display("FAIL handshake_timeout: instr=%h out_valid=%0b wait=%0d", instr, out_valid, cyc);
      end
      res = out_result;
      fl  = out_flags;
      er  = out_err;
   endtask

   task automatic test_reset;
      logic [31:0] r; logic [2:0] f; logic e; int c;
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_instr = '0;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
      checks++;
      if ({out_valid, out_err, out_flags, out_result, alu_opcode, alu_a, alu_b, alu_cin} !== '0) begin
         errors++;
         $display("FAIL rst_outputs: valid=%0b err=%0b flags=%b res=%h op=%b a=%h b=%h cin=%0b want all 0",
                  out_valid, out_err, out_flags, out_result, alu_opcode, alu_a, alu_b, alu_cin);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %0b want 1", in_ready); end

      issue(enc(OP_ADD, 1, 0, 0, 1'b0, 16'h0), r, f, e, c);
      @(posedge clk); #1;
      // LI r2,7 accepted, then reset lands in EXEC
      in_valid = 1'b1;
      in_instr = enc(OP_LI, 2, 0, 0, 1'b0, 16'd7);
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++;
      if (alu_opcode !== OP_ADD) begin errors++; $display("FAIL alu_hold_on_li: got %b want %b", alu_opcode, OP_ADD); end
      rst = 1'b1;
      #1;
      checks++;
      if (out_valid !== 1'b0 || alu_opcode !== 6'd0 || in_ready !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_exec: valid=%0b op=%b ready=%0b want 0 000000 0", out_valid, alu_opcode, in_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_exec_release: ready=%0b valid=%0b want 1 0", in_ready, out_valid);
      end
      issue(enc(OP_ADD, 3, 2, 0, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (r !== 32'd0) begin errors++; $display("FAIL rst_dropped_write: r2 read %h want 0", r); end
   endtask

   task automatic test_arith;
      logic [31:0] r; logic [2:0] f; logic e; int c;
      issue(enc(OP_LI, 1, 0, 0, 1'b0, 16'd5), r, f, e, c);
      checks++;
      if (r !== 32'd5 || f !== 3'b000 || e !== 1'b0) begin
         errors++; $display("FAIL li_r1: res=%h flags=%b err=%0b want 5 000 0", r, f, e);
      end
      issue(enc(OP_LI, 2, 0, 0, 1'b0, 16'd3), r, f, e, c);
      issue(enc(OP_ADD, 3, 1, 2, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (c !== 2) begin errors++; $display("FAIL add_latency: got %0d cycles want 2", c); end
      checks++;
      if (r !== 32'd8 || f !== 3'b000 || e !== 1'b0) begin
         errors++; $display("FAIL add_r3: res=%h flags=%b err=%0b want 8 000 0", r, f, e);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL resp_one_cycle: out_valid=%0b want 0", out_valid); end

      issue(enc(OP_SUB, 4, 2, 1, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (r !== 32'hFFFF_FFFE || f !== {CC, 2'b01}) begin
         errors++; $display("FAIL sub_r4: res=%h flags=%b want fffffffe %b", r, f, {CC, 2'b01});
      end
      checks++;
      if (alu_opcode !== OP_SUB || alu_a !== 32'd3 || alu_b !== 32'd5) begin
         errors++; $display("FAIL sub_alu_drive: op=%b a=%h b=%h want 010001 3 5", alu_opcode, alu_a, alu_b);
      end
      issue(enc(OP_EQ, 5, 4, 4, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (r !== 32'd1 || f !== {CC, 2'b00}) begin
         errors++; $display("FAIL eq_r5: res=%h flags=%b want 1 %b", r, f, {CC, 2'b00});
      end
   endtask

   task automatic test_backpressure;
      logic [31:0] r; logic [2:0] f; logic e; int c;
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(enc(OP_ADD, 6, 1, 2, 1'b0, 16'h0), r, f, e, c);
      in_valid = 1'b1;
      in_instr = enc(OP_LI, 6, 0, 0, 1'b0, 16'h1234);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (out_valid !== 1'b1 || out_result !== 32'd8 || out_flags !== 3'b000 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold_%0d: valid=%0b res=%h flags=%b ready=%0b want 1 8 000 0",
                     i, out_valid, out_result, out_flags, in_ready);
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: out_valid=%0b want 0", out_valid); end
      issue(enc(OP_ADD, 7, 6, 0, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (r !== 32'd8) begin errors++; $display("FAIL bp_ignored_instr: r6=%h want 8", r); end
   endtask

   task automatic test_illegal;
      logic [31:0] r; logic [2:0] f; logic e; int c;
      issue(enc(OP_ADD, 7, 0, 0, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (r !== 32'd0 || f !== 3'b010) begin
         errors++; $display("FAIL add_zero: res=%h flags=%b want 0 010", r, f);
      end
      issue(enc(6'b001111, 5, 1, 2, 1'b0, 16'hFFFF), r, f, e, c);
      checks++;
      if (e !== 1'b1 || r !== 32'd0 || f !== 3'b010 || c !== 2) begin
         errors++; $display("FAIL illegal_op: err=%0b res=%h flags=%b lat=%0d want 1 0 010 2", e, r, f, c);
      end
      issue(enc(OP_NOP, 5, 1, 2, 1'b0, 16'hFFFF), r, f, e, c);
      checks++;
      if (e !== 1'b0 || r !== 32'd0 || f !== 3'b010) begin
         errors++; $display("FAIL nop: err=%0b res=%h flags=%b want 0 0 010", e, r, f);
      end
      issue(enc(OP_ADD, 7, 5, 0, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (r !== 32'd1) begin errors++; $display("FAIL illegal_no_write: r5=%h want 1", r); end
   endtask

   task automatic test_carry;
      logic [31:0] r; logic [2:0] f; logic e; int c;
      issue(enc(OP_LI, 1, 0, 0, 1'b0, 16'hFFFF), r, f, e, c);
      checks++;
      if (r !== 32'h0000_FFFF || f !== 3'b000) begin
         errors++; $display("FAIL li_ffff: res=%h flags=%b want 0000ffff 000", r, f);
      end
      issue(enc(OP_SUB, 7, 0, 1, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (r !== 32'hFFFF_0001 || f !== {CC, 2'b01}) begin
         errors++; $display("FAIL sub_neg: res=%h flags=%b want ffff0001 %b", r, f, {CC, 2'b01});
      end
      issue(enc(OP_ADD, 7, 7, 1, 1'b0, 16'h0), r, f, e, c);
      checks++;
      if (r !== 32'd0 || f !== {CC, 2'b10}) begin
         errors++; $display("FAIL add_carry_out: res=%h flags=%b want 0 %b", r, f, {CC, 2'b10});
      end
      issue(enc(OP_ADD, 6, 0, 0, 1'b1, 16'h0), r, f, e, c);
      checks++;
      if (alu_cin !== CC) begin errors++; $display("FAIL carry_in: alu_cin=%0b want %0b", alu_cin, CC); end
      checks++;
      if (r !== {31'd0, CC} || f !== {1'b0, ~CC, 1'b0}) begin
         errors++; $display("FAIL add_with_carry: res=%h flags=%b want %h %b", r, f, {31'd0, CC}, {1'b0, ~CC, 1'b0});
      end
   endtask

   initial begin
      test_reset();
      test_arith();
      test_backpressure();
      test_illegal();
      test_carry();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
